apb_periph_arbiter: RTL and testbench



---
 rtl/apb_periph_arb_pkg.sv | 8 +
 rtl/rr_arb2.sv | 21 ++
 rtl/apb_periph_arbiter.sv | 137 +++++++++++++
 tb/tb_apb_periph_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_periph_arb_pkg.sv
// Shared types for the two-port APB arbiter: FSM states, grant index, requester count.
package apb_periph_arb_pkg;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  typedef logic grant_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arb2
  import apb_periph_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  grant_t             last_grant,
  output grant_t             grant,
  output logic               valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    if (req[0] && req[1]) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/apb_periph_arbiter.sv
// Two-requester APB arbiter: round-robin grant, regenerated SETUP/ACCESS on the shared bus,
// registered response back to the winner, ACCESS-phase timeout with forced error.
module apb_periph_arbiter
  import apb_periph_arb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] s0_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] s0_pwdata_i,
  input  logic                      s0_pwrite_i,
  input  logic                      s0_psel_i,
  input  logic                      s0_penable_i,
  output logic [APB_DATA_WIDTH-1:0] s0_prdata_o,
  output logic                      s0_pready_o,
  output logic                      s0_pslverr_o,
  input  logic [APB_ADDR_WIDTH-1:0] s1_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0] s1_pwdata_i,
  input  logic                      s1_pwrite_i,
  input  logic                      s1_psel_i,
  input  logic                      s1_penable_i,
  output logic [APB_DATA_WIDTH-1:0] s1_prdata_o,
  output logic                      s1_pready_o,
  output logic                      s1_pslverr_o,
  output logic [APB_ADDR_WIDTH-1:0] m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] m_pwdata_o,
  output logic                      m_pwrite_o,
  output logic                      m_psel_o,
  output logic                      m_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] m_prdata_i,
  input  logic                      m_pready_i,
  input  logic                      m_pslverr_i,
  output logic                      timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                    state, state_nxt;
  grant_t                    grant_q, last_grant_q, pick;
  logic                      pick_vld;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                      write_q, slverr_q, timeout_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      to_hit, done;

  // Requester penable carries no information the arbiter needs; SETUP/ACCESS is regenerated.
  logic unused_penable;
  assign unused_penable = &{1'b0, s0_penable_i, s1_penable_i};

  rr_arb2 u_rr_arb2 (
    .req        ({s1_psel_i, s0_psel_i}),
    .last_grant (last_grant_q),
    .grant      (pick),
    .valid      (pick_vld)
  );

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (m_pready_i || to_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      slverr_q     <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_q      <= pick;
            last_grant_q <= pick;
            addr_q       <= pick ? s1_paddr_i  : s0_paddr_i;
            wdata_q      <= pick ? s1_pwdata_i : s0_pwdata_i;
            write_q      <= pick ? s1_pwrite_i : s0_pwrite_i;
          end
        end
        ACCESS: begin
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          // A slave response in the timeout cycle takes priority over the forced error.
          if (m_pready_i) begin
            rdata_q  <= m_prdata_i;
            slverr_q <= m_pslverr_i;
          end else if (to_hit) begin
            rdata_q   <= '0;
            slverr_q  <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        DONE:    cnt_q <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    done         = (state == DONE);
    m_psel_o     = (state == SETUP) || (state == ACCESS);
    m_penable_o  = (state == ACCESS);
    m_paddr_o    = addr_q;
    m_pwdata_o   = wdata_q;
    m_pwrite_o   = write_q;
    s0_pready_o  = done && (grant_q == 1'b0);
    s1_pready_o  = done && (grant_q == 1'b1);
    s0_prdata_o  = s0_pready_o ? rdata_q : '0;
    s1_prdata_o  = s1_pready_o ? rdata_q : '0;
    s0_pslverr_o = s0_pready_o && slverr_q;
    s1_pslverr_o = s1_pready_o && slverr_q;
    timeout_o    = timeout_q;
  end

endmodule

// File: tb/tb_apb_periph_arbiter.sv
// Directed bench: default-timeout instance for normal traffic, TIMEOUT_CYCLES=4 instance for the timeout case.
module tb_apb_periph_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s0_paddr, s0_pwdata, s1_paddr, s1_pwdata, m_prdata;
  logic        s0_pwrite, s0_psel, s0_penable, s1_pwrite, s1_psel, s1_penable;
  logic        m_pready, m_pslverr;

  logic [31:0] s0_prdata, s1_prdata, m_paddr, m_pwdata;
  logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr, m_pwrite, m_psel, m_penable, timeout;
  logic [31:0] t_s0_prdata, t_s1_prdata, t_m_paddr, t_m_pwdata;
  logic        t_s0_pready, t_s0_pslverr, t_s1_pready, t_s1_pslverr, t_m_pwrite, t_m_psel, t_m_penable, t_timeout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_periph_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .s0_paddr_i(s0_paddr), .s0_pwdata_i(s0_pwdata), .s0_pwrite_i(s0_pwrite),
    .s0_psel_i(s0_psel), .s0_penable_i(s0_penable),
    .s0_prdata_o(s0_prdata), .s0_pready_o(s0_pready), .s0_pslverr_o(s0_pslverr),
    .s1_paddr_i(s1_paddr), .s1_pwdata_i(s1_pwdata), .s1_pwrite_i(s1_pwrite),
    .s1_psel_i(s1_psel), .s1_penable_i(s1_penable),
    .s1_prdata_o(s1_prdata), .s1_pready_o(s1_pready), .s1_pslverr_o(s1_pslverr),
    .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata), .m_pwrite_o(m_pwrite),
    .m_psel_o(m_psel), .m_penable_o(m_penable),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .timeout_o(timeout)
  );

  apb_periph_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .s0_paddr_i(s0_paddr), .s0_pwdata_i(s0_pwdata), .s0_pwrite_i(s0_pwrite),
    .s0_psel_i(s0_psel), .s0_penable_i(s0_penable),
    .s0_prdata_o(t_s0_prdata), .s0_pready_o(t_s0_pready), .s0_pslverr_o(t_s0_pslverr),
    .s1_paddr_i(s1_paddr), .s1_pwdata_i(s1_pwdata), .s1_pwrite_i(s1_pwrite),
    .s1_psel_i(s1_psel), .s1_penable_i(s1_penable),
    .s1_prdata_o(t_s1_prdata), .s1_pready_o(t_s1_pready), .s1_pslverr_o(t_s1_pslverr),
    .m_paddr_o(t_m_paddr), .m_pwdata_o(t_m_pwdata), .m_pwrite_o(t_m_pwrite),
    .m_psel_o(t_m_psel), .m_penable_o(t_m_penable),
    .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr),
    .timeout_o(t_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst = 1'b1;
    s0_psel = 1'b0; s0_penable = 1'b0; s1_psel = 1'b0; s1_penable = 1'b0;
    nxt(); nxt();
    rst = 1'b0;
  endtask

  initial begin
    s0_paddr = '0; s0_pwdata = '0; s0_pwrite = 1'b0;
    s1_paddr = '0; s1_pwdata = '0; s1_pwrite = 1'b0;
    m_prdata = '0; m_pready = 1'b1; m_pslverr = 1'b0;
    reset_all();

    // reset state
    chk("rst_psel", {31'd0, m_psel}, 0);
    chk("rst_penable", {31'd0, m_penable}, 0);
    chk("rst_paddr", m_paddr, 0);
    chk("rst_pready0", {31'd0, s0_pready}, 0);
    chk("rst_timeout", {31'd0, timeout}, 0);

    // single read, zero-wait slave
    s0_paddr = 32'h1A10_2000; s0_pwrite = 1'b0; s0_psel = 1'b1;
    m_prdata = 32'hDEAD_BEEF;
    nxt();
    chk("rd_c1_psel", {31'd0, m_psel}, 1);
    chk("rd_c1_penable", {31'd0, m_penable}, 0);
    chk("rd_c1_paddr", m_paddr, 32'h1A10_2000);
    s0_penable = 1'b1;
    nxt();
    chk("rd_c2_penable", {31'd0, m_penable}, 1);
    nxt();
    chk("rd_c3_pready0", {31'd0, s0_pready}, 1);
    chk("rd_c3_prdata0", s0_prdata, 32'hDEAD_BEEF);
    chk("rd_c3_pslverr0", {31'd0, s0_pslverr}, 0);
    chk("rd_c3_pready1", {31'd0, s1_pready}, 0);
    chk("rd_c3_prdata1", s1_prdata, 0);
    chk("rd_c3_psel", {31'd0, m_psel}, 0);
    s0_psel = 1'b0; s0_penable = 1'b0;
    nxt();
    chk("rd_c4_pready0", {31'd0, s0_pready}, 0);
    chk("rd_c4_prdata0", s0_prdata, 0);

    // simultaneous writes straight after reset: s0 first, s1 second
    reset_all();
    s0_paddr = 32'h100; s0_pwdata = 32'h11; s0_pwrite = 1'b1; s0_psel = 1'b1;
    s1_paddr = 32'h200; s1_pwdata = 32'h22; s1_pwrite = 1'b1; s1_psel = 1'b1;
    nxt();
    chk("sim_c1_pwdata", m_pwdata, 32'h11);
    chk("sim_c1_paddr", m_paddr, 32'h100);
    chk("sim_c1_pwrite", {31'd0, m_pwrite}, 1);
    nxt(); nxt();
    chk("sim_c3_pready0", {31'd0, s0_pready}, 1);
    chk("sim_c3_pready1", {31'd0, s1_pready}, 0);
    s0_psel = 1'b0;
    nxt();
    chk("sim_c4_psel", {31'd0, m_psel}, 0);
    nxt();
    chk("sim_c5_pwdata", m_pwdata, 32'h22);
    chk("sim_c5_paddr", m_paddr, 32'h200);
    nxt(); nxt();
    chk("sim_c7_pready1", {31'd0, s1_pready}, 1);
    chk("sim_c7_pready0", {31'd0, s0_pready}, 0);
    s1_psel = 1'b0;
    nxt();

    // fairness: both hold psel for 8 transfers, last grant was s1 so s0 leads
    s0_paddr = 32'hA0; s0_pwrite = 1'b0; s0_psel = 1'b1;
    s1_paddr = 32'hB0; s1_pwrite = 1'b0; s1_psel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nxt();
      chk($sformatf("fair%0d_paddr", i), m_paddr, (i % 2 == 0) ? 32'hA0 : 32'hB0);
      nxt(); nxt();
      chk($sformatf("fair%0d_pready0", i), {31'd0, s0_pready}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("fair%0d_pready1", i), {31'd0, s1_pready}, (i % 2 == 0) ? 0 : 1);
      if (i == 7) begin
        s0_psel = 1'b0; s1_psel = 1'b0;
      end
      nxt();
    end

    // five wait states then slave error
    s0_paddr = 32'h300; s0_psel = 1'b1; m_pready = 1'b0;
    nxt();
    chk("ws_c1_penable", {31'd0, m_penable}, 0);
    for (int i = 2; i <= 6; i++) begin
      nxt();
      chk($sformatf("ws_c%0d_penable", i), {31'd0, m_penable}, 1);
      chk($sformatf("ws_c%0d_pready0", i), {31'd0, s0_pready}, 0);
    end
    nxt();
    chk("ws_c7_penable", {31'd0, m_penable}, 1);
    m_pready = 1'b1; m_pslverr = 1'b1; m_prdata = 32'h5A5A_5A5A;
    nxt();
    chk("ws_c8_pready0", {31'd0, s0_pready}, 1);
    chk("ws_c8_pslverr0", {31'd0, s0_pslverr}, 1);
    chk("ws_c8_prdata0", s0_prdata, 32'h5A5A_5A5A);
    chk("ws_c8_timeout", {31'd0, timeout}, 0);
    s0_psel = 1'b0; m_pslverr = 1'b0;
    nxt();

    // timeout on the TIMEOUT_CYCLES=4 instance, queued s1 request afterwards
    reset_all();
    m_pready = 1'b0; m_prdata = 32'hFFFF_FFFF; m_pslverr = 1'b0;
    s0_paddr = 32'h400; s0_psel = 1'b1;
    s1_paddr = 32'h500; s1_psel = 1'b1;
    nxt();
    chk("to_c1_paddr", t_m_paddr, 32'h400);
    for (int i = 2; i <= 5; i++) begin
      nxt();
      chk($sformatf("to_c%0d_penable", i), {31'd0, t_m_penable}, 1);
      chk($sformatf("to_c%0d_timeout", i), {31'd0, t_timeout}, 0);
    end
    nxt();
    chk("to_c6_penable", {31'd0, t_m_penable}, 0);
    chk("to_c6_pready0", {31'd0, t_s0_pready}, 1);
    chk("to_c6_pslverr0", {31'd0, t_s0_pslverr}, 1);
    chk("to_c6_prdata0", t_s0_prdata, 0);
    chk("to_c6_timeout", {31'd0, t_timeout}, 1);
    s0_psel = 1'b0;
    nxt();
    chk("to_c7_timeout", {31'd0, t_timeout}, 0);
    chk("to_c7_pready0", {31'd0, t_s0_pready}, 0);
    nxt();
    chk("to_c8_paddr", t_m_paddr, 32'h500);
    chk("to_c8_psel", {31'd0, t_m_psel}, 1);
    m_pready = 1'b1;
    nxt();
    chk("to_c9_penable", {31'd0, t_m_penable}, 1);
    nxt();
    chk("to_c10_pready1", {31'd0, t_s1_pready}, 1);
    chk("to_c10_pslverr1", {31'd0, t_s1_pslverr}, 0);
    chk("to_c10_prdata1", t_s1_prdata, 32'hFFFF_FFFF);
    chk("to_c10_timeout", {31'd0, t_timeout}, 0);
    s1_psel = 1'b0;
    nxt();

    // reset asserted during ACCESS
    reset_all();
    m_pready = 1'b0;
    s1_paddr = 32'h600; s1_psel = 1'b1;
    nxt(); nxt();
    chk("rm_c2_penable", {31'd0, m_penable}, 1);
    rst = 1'b1;
    #1;
    chk("rm_async_psel", {31'd0, m_psel}, 0);
    chk("rm_async_penable", {31'd0, m_penable}, 0);
    chk("rm_async_paddr", m_paddr, 0);
    chk("rm_async_pready1", {31'd0, s1_pready}, 0);
    nxt(); nxt();
    chk("rm_hold_pready1", {31'd0, s1_pready}, 0);
    chk("rm_hold_psel", {31'd0, m_psel}, 0);
    rst = 1'b0;
    m_pready = 1'b1;
    s0_paddr = 32'h700; s0_psel = 1'b1;
    nxt();
    chk("rm_c1_paddr", m_paddr, 32'h700);
    nxt(); nxt();
    chk("rm_c3_pready0", {31'd0, s0_pready}, 1);
    chk("rm_c3_pready1", {31'd0, s1_pready}, 0);
    s0_psel = 1'b0; s1_psel = 1'b0;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
